// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI arbiter slice: FSM states, default word width
// and the round-robin search used by the requester picker.
package spi_pkg;

    localparam int unsigned DEFAULT_SPI_DATA_WIDTH = 32;
    localparam int unsigned MAX_REQ                = 8;
    localparam int unsigned MAX_IDX_W              = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RELEASE
    } arb_state_t;

    typedef struct packed {
        logic        valid;
        int unsigned idx;
    } rr_pick_t;

    // First set bit of req[0..n-1] searching upward from ptr, wrapping at n.
    function automatic rr_pick_t rr_select(input logic [MAX_REQ-1:0] req,
                                           input int unsigned        ptr,
                                           input int unsigned        n);
        rr_pick_t    pick;
        int unsigned j;
        pick = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n && !pick.valid) begin
                j = (ptr + i) % n;
                if (req[j[MAX_IDX_W-1:0]]) begin
                    pick.valid = 1'b1;
                    pick.idx   = j;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Round-robin requester picker: combinational search from a registered pointer that
// moves to one past the winner whenever a grant is taken.
module spi_rr_picker
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    rr_pick_t         pick;

    always_comb begin
        pick  = rr_select(MAX_REQ'(req), 32'(ptr_q), NUM_REQ);
        idx   = IDX_W'(pick.idx);
        valid = pick.valid;
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (32'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master among NUM_REQ requesters, one whole transaction per grant,
// with a saturating watchdog that aborts a transaction whose done never comes.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned SPI_DATA_WIDTH = DEFAULT_SPI_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic [NUM_REQ-1:0]                i_req,
    input  logic [NUM_REQ*SPI_DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]                o_gnt,
    output logic [NUM_REQ-1:0]                o_req_done,
    output logic [NUM_REQ-1:0]                o_req_err,
    output logic [SPI_DATA_WIDTH-1:0]         o_req_rdata,
    output logic                              o_spi_enable,
    output logic [SPI_DATA_WIDTH-1:0]         o_spi_data,
    input  logic                              i_spi_done,
    input  logic                              i_spi_busy,
    input  logic [SPI_DATA_WIDTH-1:0]         i_spi_data
);

    localparam int unsigned IDX_W    = $clog2(NUM_REQ);
    localparam int unsigned WD_W     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned WD_LIMIT = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);

    arb_state_t                state_q, state_d;
    logic [NUM_REQ-1:0]        gnt_q, gnt_d;
    logic [IDX_W-1:0]          owner_q, owner_d;
    logic [SPI_DATA_WIDTH-1:0] tx_q, tx_d;
    logic [SPI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      en_q, en_d;
    logic [NUM_REQ-1:0]        done_q, done_d;
    logic [NUM_REQ-1:0]        err_q, err_d;
    logic [WD_W-1:0]           wd_q, wd_d;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_valid;
    logic                      advance;
    logic                      timeout;

    spi_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .req     (i_req),
        .advance (advance),
        .idx     (pick_idx),
        .valid   (pick_valid)
    );

    // Counts only while ACTIVE and sticks at the limit instead of wrapping.
    always_comb begin
        wd_d = wd_q;
        if (state_q != ACTIVE) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + 1'b1;
        end
    end

    assign timeout = (TIMEOUT_CYCLES != 0) && (wd_q == WD_MAX);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        tx_d    = tx_q;
        rdata_d = rdata_q;
        en_d    = en_q;
        done_d  = '0;
        err_d   = '0;
        advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid && !i_spi_busy) begin
                    advance         = 1'b1;
                    state_d         = ACTIVE;
                    owner_d         = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    tx_d            = i_req_data[32'(pick_idx) * SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
                    en_d            = 1'b1;
                end
            end
            ACTIVE: begin
                // Done has priority over a watchdog expiry in the same cycle.
                if (i_spi_done) begin
                    state_d         = RELEASE;
                    gnt_d           = '0;
                    en_d            = 1'b0;
                    done_d[owner_q] = 1'b1;
                    rdata_d         = i_spi_data;
                end else if (timeout) begin
                    state_d        = RELEASE;
                    gnt_d          = '0;
                    en_d           = 1'b0;
                    err_d[owner_q] = 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            tx_q    <= '0;
            rdata_q <= '0;
            en_q    <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            tx_q    <= tx_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign o_gnt        = gnt_q;
    assign o_req_done   = done_q;
    assign o_req_err    = err_q;
    assign o_req_rdata  = rdata_q;
    assign o_spi_enable = en_q;
    assign o_spi_data   = tx_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: a default-watchdog instance and a 16-cycle-watchdog
// instance share one stimulus stream; each section starts from reset.
module tb_spi_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 32;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic              spi_done;
    logic              spi_busy;
    logic [W-1:0]      spi_rdata;

    logic [NREQ-1:0] a_gnt, a_done, a_err;
    logic [W-1:0]    a_rdata, a_tx;
    logic            a_en;
    logic [NREQ-1:0] b_gnt, b_done, b_err;
    logic [W-1:0]    b_rdata, b_tx;
    logic            b_en;

    int checks;
    int failures;

    spi_arbiter #(
        .NUM_REQ        (NREQ),
        .SPI_DATA_WIDTH (W),
        .TIMEOUT_CYCLES (4096)
    ) u_dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_req        (req),
        .i_req_data   (req_data),
        .o_gnt        (a_gnt),
        .o_req_done   (a_done),
        .o_req_err    (a_err),
        .o_req_rdata  (a_rdata),
        .o_spi_enable (a_en),
        .o_spi_data   (a_tx),
        .i_spi_done   (spi_done),
        .i_spi_busy   (spi_busy),
        .i_spi_data   (spi_rdata)
    );

    spi_arbiter #(
        .NUM_REQ        (NREQ),
        .SPI_DATA_WIDTH (W),
        .TIMEOUT_CYCLES (16)
    ) u_dut_wd (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_req        (req),
        .i_req_data   (req_data),
        .o_gnt        (b_gnt),
        .o_req_done   (b_done),
        .o_req_err    (b_err),
        .o_req_rdata  (b_rdata),
        .o_spi_enable (b_en),
        .o_spi_data   (b_tx),
        .i_spi_done   (spi_done),
        .i_spi_busy   (spi_busy),
        .i_spi_data   (spi_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        spi_done = 1'b0;
        spi_busy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req       = '0;
        spi_done  = 1'b0;
        spi_busy  = 1'b0;
        spi_rdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_data[k*W +: W] = 32'h1111_1111 * (k + 1);
        end

        // Reset state
        tick();
        tick();
        chk("rst_en", {31'd0, a_en}, 32'd0);
        chk("rst_gnt", {28'd0, a_gnt}, 32'd0);
        chk("rst_pulses", {24'd0, a_done, a_err}, 32'd0);
        chk("rst_tx", a_tx, 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        rst_n = 1'b1;

        // Single requester, 40-cycle transaction
        req_data[2*W +: W] = 32'h0040_C307;
        req = 4'b0100;
        tick();
        chk("single_en", {31'd0, a_en}, 32'd1);
        chk("single_gnt", {28'd0, a_gnt}, 32'h4);
        chk("single_tx", a_tx, 32'h0040_C307);
        req_data[2*W +: W] = 32'hDEAD_BEEF;
        for (int i = 1; i < 40; i++) begin
            tick();
            chk("single_hold", {a_en, a_tx[30:0]}, {1'b1, 31'h0040_C307});
        end
        spi_done  = 1'b1;
        spi_rdata = 32'h5A5A_0F0F;
        tick();
        spi_done = 1'b0;
        req      = '0;
        chk("single_done", {28'd0, a_done}, 32'h4);
        chk("single_err", {28'd0, a_err}, 32'd0);
        chk("single_off", {27'd0, a_en, a_gnt}, 32'd0);
        chk("single_rdata", a_rdata, 32'h5A5A_0F0F);
        tick();
        chk("single_pulse1", {28'd0, a_done}, 32'd0);
        tick();
        spi_done  = 1'b1;
        spi_rdata = 32'h0000_1234;
        tick();
        spi_done = 1'b0;
        chk("idle_done_ign", {27'd0, a_en, a_done}, 32'd0);
        chk("idle_rdata", a_rdata, 32'h5A5A_0F0F);

        // Fairness with all requests held
        req_data[2*W +: W] = 32'h3333_3333;
        do_reset();
        req = 4'b1111;
        for (int r = 0; r < 6; r++) begin
            tick();
            chk("fair_gnt", {28'd0, a_gnt}, 32'd1 << (r % 4));
            chk("fair_tx", a_tx, 32'h1111_1111 * ((r % 4) + 1));
            repeat (3) tick();
            spi_done  = 1'b1;
            spi_rdata = 32'hC0DE_0000 + r;
            tick();
            spi_done = 1'b0;
            chk("fair_done", {28'd0, a_done}, 32'd1 << (r % 4));
            chk("fair_low1", {31'd0, a_en}, 32'd0);
            tick();
            chk("fair_low2", {27'd0, a_en, a_gnt}, 32'd0);
        end

        // Busy gating
        do_reset();
        req      = 4'b0010;
        spi_busy = 1'b1;
        repeat (3) begin
            tick();
            chk("busy_block", {27'd0, a_en, a_gnt}, 32'd0);
        end
        spi_busy = 1'b0;
        tick();
        chk("busy_gnt", {27'd0, a_en, a_gnt}, {27'd0, 1'b1, 4'b0010});
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        req      = '0;
        chk("busy_done", {28'd0, a_done}, 32'h2);
        tick();
        tick();

        // Watchdog expiry on the 16-cycle instance
        do_reset();
        req = 4'b0011;
        tick();
        chk("to_gnt", {27'd0, b_en, b_gnt}, {27'd0, 1'b1, 4'b0001});
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("to_wait", {23'd0, b_done, b_err, b_en}, 32'd1);
        end
        tick();
        req = 4'b0010;
        chk("to_err", {28'd0, b_err}, 32'h1);
        chk("to_nodone", {28'd0, b_done}, 32'd0);
        chk("to_off", {27'd0, b_en, b_gnt}, 32'd0);
        chk("to_rdata", b_rdata, 32'd0);
        tick();
        chk("to_pulse1", {27'd0, b_en, b_err}, 32'd0);
        tick();
        chk("to_next", {27'd0, b_en, b_gnt}, {27'd0, 1'b1, 4'b0010});
        spi_done  = 1'b1;
        spi_rdata = 32'h0000_0077;
        tick();
        spi_done = 1'b0;
        req      = '0;
        chk("to_next_done", {28'd0, b_done}, 32'h2);
        tick();
        tick();

        // Done on the cycle the watchdog expires
        do_reset();
        req = 4'b0100;
        tick();
        chk("sim_gnt", {28'd0, b_gnt}, 32'h4);
        repeat (16) tick();
        spi_done  = 1'b1;
        spi_rdata = 32'hFACE_0001;
        tick();
        spi_done = 1'b0;
        req      = '0;
        chk("sim_done", {28'd0, b_done}, 32'h4);
        chk("sim_noerr", {28'd0, b_err}, 32'd0);
        chk("sim_rdata", b_rdata, 32'hFACE_0001);
        tick();
        tick();
        chk("sim_noerr_late", {28'd0, b_err}, 32'd0);

        // Request dropped while ACTIVE
        do_reset();
        req = 4'b1000;
        tick();
        chk("drop_gnt", {28'd0, a_gnt}, 32'h8);
        tick();
        req = '0;
        tick();
        tick();
        chk("drop_hold", {27'd0, a_en, a_gnt}, {27'd0, 1'b1, 4'b1000});
        spi_done  = 1'b1;
        spi_rdata = 32'h0BAD_CAFE;
        tick();
        spi_done = 1'b0;
        chk("drop_done", {28'd0, a_done}, 32'h8);
        chk("drop_rdata", a_rdata, 32'h0BAD_CAFE);
        tick();
        tick();

        // Asynchronous reset mid-transaction
        req = 4'b0110;
        tick();
        chk("mrst_gnt", {28'd0, a_gnt}, 32'h2);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_async", {27'd0, a_en, a_gnt}, 32'd0);
        chk("mrst_tx", a_tx, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mrst_regrant", {27'd0, a_en, a_gnt}, {27'd0, 1'b1, 4'b0010});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
